gin_multicast_receiver: RTL and testbench

- PE-array-side endpoint of one global input network (GIN) channel.
- Pops {row_tag, col_tag} pairs and data words from the tag and GIN FIFOs that the GLB-side NoC controller fills.
- Matches each tag against per-PE programmed IDs and multicasts the word to every matching PE with a valid/ready handshake.
- Counts delivered and dropped packets and raises done once a programmed packet count is reached.

---
 rtl/gin_pkg.sv | 8 +
 rtl/multicast_id_match.sv | 33 +++
 rtl/gin_multicast_receiver.sv | 95 +++++++++
 tb/tb_gin_multicast_receiver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gin_pkg.sv
// gin_pkg: shared state encoding and default sizing for the GIN multicast receiver.
package gin_pkg;
  typedef enum logic [1:0] {IDLE, READ, SEND} gin_state_e;
  localparam int NUM_ROWS_DEF = 12;
  localparam int NUM_COLS_DEF = 14;
  localparam int NUM_PE = NUM_ROWS_DEF * NUM_COLS_DEF;
  localparam int PE_IDX_W = 8;
endpackage

// File: rtl/multicast_id_match.sv
// multicast_id_match: one PE's programmable row/col ID and enable, with a combinational tag match.
module multicast_id_match #(
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ROW_TAG_WIDTH-1:0] wr_row_id,
  input  logic [COL_TAG_WIDTH-1:0] wr_col_id,
  input  logic                     wr_en,
  input  logic [ROW_TAG_WIDTH-1:0] row_tag,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  output logic                     match
);
  logic [ROW_TAG_WIDTH-1:0] row_id_q, row_id_d;
  logic [COL_TAG_WIDTH-1:0] col_id_q, col_id_d;
  logic en_q, en_d;
  always_comb begin
    row_id_d = we ? wr_row_id : row_id_q;
    col_id_d = we ? wr_col_id : col_id_q;
    en_d = we ? wr_en : en_q;
  end
  // IDs carry no reset; the enable alone gates matching
  always_ff @(posedge clk) begin
    row_id_q <= row_id_d;
    col_id_q <= col_id_d;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) en_q <= 1'b0;
    else en_q <= en_d;
  assign match = en_q && row_id_q == row_tag && col_id_q == col_tag;
endmodule

// File: rtl/gin_multicast_receiver.sv
// gin_multicast_receiver: pops tag/data pairs from the GIN FIFOs and multicasts each word
// to every PE whose programmed IDs match, counting packets toward a done level.
module gin_multicast_receiver
  import gin_pkg::*;
#(
  parameter int NUM_ROWS      = 12,
  parameter int NUM_COLS      = 14,
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           num_packets,
  output logic                           done,
  output logic                           drop_pulse,
  input  logic                           cfg_we,
  input  logic [PE_IDX_W-1:0]            cfg_pe_idx,
  input  logic [ROW_TAG_WIDTH-1:0]       cfg_row_id,
  input  logic [COL_TAG_WIDTH-1:0]       cfg_col_id,
  input  logic                           cfg_en,
  input  logic                           tags_fifo_empty,
  output logic                           re_tags_fifo,
  input  logic [ROW_TAG_WIDTH-1:0]       row_tag,
  input  logic [COL_TAG_WIDTH-1:0]       col_tag,
  input  logic                           gin_fifo_empty,
  output logic                           re_from_gin_fifo,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [NUM_ROWS*NUM_COLS-1:0]   pe_valid,
  input  logic [NUM_ROWS*NUM_COLS-1:0]   pe_ready,
  output logic [DATA_WIDTH-1:0]          pe_data
);
  localparam int N = NUM_ROWS * NUM_COLS;
  gin_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [N-1:0] match_q, match_d, accepted_q, accepted_d, match_now, fire;
  logic [CNT_WIDTH-1:0] processed_q, processed_d, num_packets_q, num_packets_d, base;
  logic armed_q, armed_d, pop, complete;
  for (genvar i = 0; i < N; i++) begin : g_pe
    multicast_id_match #(
      .ROW_TAG_WIDTH(ROW_TAG_WIDTH),
      .COL_TAG_WIDTH(COL_TAG_WIDTH)
    ) u_match (
      .clk       (clk),
      .reset     (reset),
      .we        (cfg_we && cfg_pe_idx == PE_IDX_W'(i)),
      .wr_row_id (cfg_row_id),
      .wr_col_id (cfg_col_id),
      .wr_en     (cfg_en),
      .row_tag   (row_tag),
      .col_tag   (col_tag),
      .match     (match_now[i])
    );
  end
  // A zero match set completes immediately and is reported as a drop
  always_comb begin
    pop = state_q == IDLE && !tags_fifo_empty && !gin_fifo_empty;
    pe_valid = state_q == SEND ? match_q & ~accepted_q : '0;
    fire = pe_valid & pe_ready;
    complete = state_q == SEND && (accepted_q | fire) == match_q;
    drop_pulse = state_q == SEND && match_q == '0;
    state_d = state_q == IDLE ? (pop ? READ : IDLE) : state_q == READ ? SEND : complete ? IDLE : SEND;
    data_d = state_q == READ ? din : data_q;
    match_d = state_q == READ ? match_now : match_q;
    accepted_d = complete ? '0 : accepted_q | fire;
    base = start ? '0 : processed_q;
    processed_d = base + CNT_WIDTH'(complete && !(&base));
    num_packets_d = start ? num_packets : num_packets_q;
    armed_d = armed_q | start;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      match_q <= '0;
      accepted_q <= '0;
      processed_q <= '0;
      num_packets_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      match_q <= match_d;
      accepted_q <= accepted_d;
      processed_q <= processed_d;
      num_packets_q <= num_packets_d;
      armed_q <= armed_d;
    end
  assign re_tags_fifo = pop;
  assign re_from_gin_fifo = pop;
  assign pe_data = data_q;
  assign done = armed_q && processed_q == num_packets_q;
endmodule

// File: tb/tb_gin_multicast_receiver.sv
// tb_gin_multicast_receiver: directed and randomized checks against a tag-match reference model.
module tb_gin_multicast_receiver;
  localparam int N = 168;
  logic clk = 0, reset = 1, start = 0, cfg_we = 0, cfg_en = 0;
  logic [15:0] num_packets = 0;
  logic [7:0] cfg_pe_idx = 0;
  logic [3:0] cfg_row_id = 0, row_tag = 0;
  logic [4:0] cfg_col_id = 0, col_tag = 0;
  logic tags_fifo_empty = 1, gin_fifo_empty = 1;
  logic [15:0] din = 0, pe_data, cur_data = 0;
  logic [N-1:0] pe_ready = '0, pe_valid, rem = '0, cur_mask = '0, m1;
  logic done, drop_pulse, re_tags_fifo, re_from_gin_fifo;
  int n_cmp = 0, n_err = 0, cyc_cnt = 0, t0, t1, t2, pushed;
  bit active = 0;
  logic [8:0] tq[$];
  logic [15:0] dq[$];
  logic [3:0] m_row[N];
  logic [4:0] m_col[N];
  bit m_en[N];

  gin_multicast_receiver dut (
    .clk(clk), .reset(reset), .start(start), .num_packets(num_packets), .done(done),
    .drop_pulse(drop_pulse), .cfg_we(cfg_we), .cfg_pe_idx(cfg_pe_idx), .cfg_row_id(cfg_row_id),
    .cfg_col_id(cfg_col_id), .cfg_en(cfg_en), .tags_fifo_empty(tags_fifo_empty),
    .re_tags_fifo(re_tags_fifo), .row_tag(row_tag), .col_tag(col_tag),
    .gin_fifo_empty(gin_fifo_empty), .re_from_gin_fifo(re_from_gin_fifo), .din(din),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Synchronous-read FIFO model: pop on the edge, empty flags refreshed mid low phase
  always begin
    @(posedge clk);
    if (re_tags_fifo && tq.size() > 0) {row_tag, col_tag} <= tq.pop_front();
    if (re_from_gin_fifo && dq.size() > 0) din <= dq.pop_front();
    @(negedge clk);
    #4;
    tags_fifo_empty = tq.size() == 0;
    gin_fifo_empty = dq.size() == 0;
  end

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_mask(input logic [3:0] r, input logic [4:0] c);
    for (int i = 0; i < N; i++) exp_mask[i] = m_en[i] && m_row[i] == r && m_col[i] == c;
  endfunction

  // Scoreboard: each popped packet's target set must be delivered exactly once
  always @(negedge clk) begin
    #7;
    if (reset) begin
      active = 0;
      rem = '0;
    end else begin
      if (|pe_valid) chk("valid_vs_remaining", pe_valid, rem);
      if (|(pe_valid & pe_ready)) begin
        chk("pe_data_on_accept", N'(pe_data), N'(cur_data));
        rem = rem & ~(pe_valid & pe_ready);
      end
      if (drop_pulse) chk("drop_only_if_no_target", cur_mask, '0);
      if (re_tags_fifo || re_from_gin_fifo) begin
        chk("paired_pop", N'({re_tags_fifo, re_from_gin_fifo}), N'(2'b11));
        chk("pop_nonempty", N'(tq.size() > 0 && dq.size() > 0), N'(1));
        if (active) chk("prev_all_delivered", rem, '0);
        if (tq.size() > 0 && dq.size() > 0) begin
          cur_mask = exp_mask(tq[0][8:5], tq[0][4:0]);
          cur_data = dq[0];
          rem = cur_mask;
          active = 1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_pop(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if (k > 0) cyc(1);
      #3;
      if (re_tags_fifo) begin
        t = cyc_cnt;
        break;
      end
    end
    chk("pop_seen", N'(t >= 0), N'(1));
  endtask

  task automatic cfg(input int idx, input int r, input int c, input bit en);
    cfg_we = 1;
    cfg_pe_idx = 8'(idx);
    cfg_row_id = 4'(r);
    cfg_col_id = 5'(c);
    cfg_en = en;
    if (idx < N) begin
      m_row[idx] = 4'(r);
      m_col[idx] = 5'(c);
      m_en[idx] = en;
    end
    cyc(1);
    cfg_we = 0;
  endtask

  task automatic start_pass(input int n);
    num_packets = 16'(n);
    start = 1;
    cyc(1);
    start = 0;
  endtask

  task automatic push(input int r, input int c, input int d);
    tq.push_back({4'(r), 5'(c)});
    dq.push_back(16'(d));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_row[i] = 0;
      m_col[i] = 0;
    end
    cyc(2);
    reset = 0;
    chk("reset_done", N'(done), '0);
    chk("reset_valid", pe_valid, '0);
    chk("reset_re", N'({re_tags_fifo, re_from_gin_fifo}), '0);
    chk("reset_drop", N'(drop_pulse), '0);
    chk("reset_data", N'(pe_data), '0);
    start_pass(0);
    chk("zero_packets_done", N'(done), N'(1));
    // single unicast to PE(2,3)
    cfg(31, 2, 3, 1);
    pe_ready = '1;
    start_pass(1);
    chk("done_after_start", N'(done), '0);
    push(2, 3, 'hBEEF);
    wait_pop(4, t0);
    cyc(2);
    chk("unicast_valid", pe_valid, exp_mask(2, 3));
    chk("unicast_bit31", pe_valid, N'(1) << 31);
    chk("unicast_data", N'(pe_data), N'(16'hBEEF));
    cyc(1);
    chk("unicast_done", N'(done), N'(1));
    chk("unicast_valid_drop", pe_valid, '0);
    // unmatched tag, including an out-of-range config write that must be ignored
    cfg(200, 9, 9, 1);
    start_pass(1);
    push(9, 9, 'h0F0F);
    wait_pop(4, t0);
    cyc(2);
    chk("drop_pulse", N'(drop_pulse), N'(1));
    chk("drop_no_valid", pe_valid, '0);
    cyc(1);
    chk("drop_one_cycle", N'(drop_pulse), '0);
    chk("drop_done", N'(done), N'(1));
    // row-0 multicast with one slow PE and a mid-SEND config write
    for (int c = 0; c < 14; c++) cfg(c, 0, 5, 1);
    pe_ready = '1;
    pe_ready[7] = 1'b0;
    start_pass(1);
    push(0, 5, 'h1234);
    wait_pop(4, t0);
    cyc(2);
    m1 = exp_mask(0, 5);
    chk("mc_valid", pe_valid, m1);
    chk("mc_data", N'(pe_data), N'(16'h1234));
    push(2, 3, 'h5555);
    cfg(7, 0, 5, 0);
    for (int s = 2; s <= 4; s++) begin
      chk("mc_slow_valid", pe_valid, m1 & ~pe_ready);
      chk("mc_no_pop", N'(re_tags_fifo), '0);
      chk("mc_data_held", N'(pe_data), N'(16'h1234));
      if (s < 4) cyc(1);
    end
    pe_ready[7] = 1'b1;
    cyc(1);
    chk("mc_valid_drop", pe_valid, '0);
    chk("mc_done", N'(done), N'(1));
    chk("mc_next_pop", N'(re_tags_fifo), N'(1));
    cfg(7, 0, 5, 1);
    cyc(1);
    chk("second_valid", pe_valid, exp_mask(2, 3));
    cyc(1);
    chk("overshoot_not_done", N'(done), '0);
    // tag FIFO non-empty while the data FIFO stays empty
    tq.push_back({4'd2, 5'd3});
    for (int s = 0; s < 5; s++) begin
      cyc(1);
      chk("stall_re_tags", N'(re_tags_fifo), '0);
      chk("stall_re_gin", N'(re_from_gin_fifo), '0);
    end
    dq.push_back(16'hCAFE);
    wait_pop(1, t0);
    cyc(2);
    chk("stall_data", N'(pe_data), N'(16'hCAFE));
    cyc(1);
    // back-to-back packets
    start_pass(3);
    push(2, 3, 1);
    push(0, 5, 2);
    push(9, 9, 3);
    wait_pop(4, t0);
    cyc(1);
    wait_pop(4, t1);
    chk("b2b_gap1", N'(t1 - t0), N'(3));
    cyc(1);
    wait_pop(4, t2);
    chk("b2b_gap2", N'(t2 - t1), N'(3));
    cyc(2);
    chk("b2b_not_done_in_send", N'(done), '0);
    cyc(1);
    chk("b2b_done", N'(done), N'(1));
    start_pass(5);
    chk("restart_clears_done", N'(done), '0);
    // reset in the middle of SEND
    pe_ready = '0;
    push(2, 3, 'hAAAA);
    wait_pop(4, t0);
    cyc(2);
    chk("pre_reset_valid", pe_valid, exp_mask(2, 3));
    reset = 1;
    #1;
    chk("async_valid_drop", pe_valid, '0);
    for (int i = 0; i < N; i++) m_en[i] = 0;
    cyc(1);
    reset = 0;
    cyc(1);
    chk("post_reset_done", N'(done), '0);
    chk("post_reset_re", N'(re_tags_fifo), '0);
    chk("post_reset_valid", pe_valid, '0);
    pe_ready = '1;
    push(2, 3, 'hBBBB);
    wait_pop(4, t0);
    cyc(2);
    chk("en_cleared_drop", N'(drop_pulse), N'(1));
    chk("en_cleared_no_valid", pe_valid, '0);
    cyc(1);
    // randomized traffic, config churn and ready back-pressure
    start_pass(40);
    pushed = 0;
    for (int k = 0; k < 4000 && !(pushed == 40 && done === 1'b1); k++) begin
      for (int i = 0; i < N; i++) pe_ready[i] = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) begin
        cfg_we = 1;
        cfg_pe_idx = 8'($urandom_range(0, 179));
        cfg_row_id = 4'($urandom_range(0, 3));
        cfg_col_id = 5'($urandom_range(0, 3));
        cfg_en = 1'($urandom_range(0, 3) != 0);
        if (cfg_pe_idx < N) begin
          m_row[cfg_pe_idx] = cfg_row_id;
          m_col[cfg_pe_idx] = cfg_col_id;
          m_en[cfg_pe_idx] = cfg_en;
        end
      end else cfg_we = 0;
      if (pushed < 40 && tq.size() < 2 && $urandom_range(0, 1) == 1) begin
        push($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
        pushed++;
      end
      cyc(1);
    end
    cfg_we = 0;
    chk("random_done", N'(done), N'(1));
    pe_ready = '1;
    cyc(3);
    chk("random_all_delivered", rem, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
